// File: rtl/gun_position_pkg.sv
// Shared widths, clamp limits and axis FSM encoding for the gun crosshair integrator.
package gun_position_pkg;

  localparam int unsigned POS_W      = 6;
  localparam int unsigned FRAC_W     = 4;
  localparam int unsigned POS_MAX    = 63;
  localparam int unsigned CENTER     = 32;
  localparam int unsigned ACC_W      = POS_W + FRAC_W;
  localparam int unsigned NXT_W      = ACC_W + 2;
  localparam int unsigned ACC_LIMIT  = (POS_MAX << FRAC_W) + (2**FRAC_W - 1);
  localparam int unsigned ACC_CENTER = CENTER << FRAC_W;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    CRUISE
  } axis_state_t;

  // Saturate a signed candidate position into the unsigned accumulator range.
  function automatic logic [ACC_W-1:0] sat_clamp(input logic signed [NXT_W-1:0] nxt);
    logic signed [NXT_W-1:0] lim;
    lim = $signed(NXT_W'(ACC_LIMIT));
    if (nxt[NXT_W-1]) return '0;
    if (nxt > lim) return ACC_W'(ACC_LIMIT);
    return nxt[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/gun_position_if.sv
// Control inputs and crosshair outputs of gun_position, bundled for the top-level port.
interface gun_position_if;
  import gun_position_pkg::*;

  logic                    tick_4ms;
  logic                    joy_right;
  logic                    joy_left;
  logic                    joy_down;
  logic                    joy_up;
  logic                    analog_en;
  logic signed [7:0]       analog_x;
  logic signed [7:0]       analog_y;
  logic                    recenter;
  logic [POS_W-1:0]        gun_h;
  logic [POS_W-1:0]        gun_v;
  logic                    moving;

  modport master (
    output tick_4ms, joy_right, joy_left, joy_down, joy_up,
    output analog_en, analog_x, analog_y, recenter,
    input  gun_h, gun_v, moving
  );

  modport slave (
    input  tick_4ms, joy_right, joy_left, joy_down, joy_up,
    input  analog_en, analog_x, analog_y, recenter,
    output gun_h, gun_v, moving
  );

endinterface

// File: rtl/gun_axis.sv
// One crosshair axis: digital acceleration FSM, analog proportional override,
// and the saturating fixed-point position accumulator.
module gun_axis
  import gun_position_pkg::*;
#(
  parameter int unsigned SPEED_MIN    = 4,
  parameter int unsigned SPEED_MAX    = 32,
  parameter int unsigned ACCEL_TICKS  = 8,
  parameter int unsigned DEADZONE     = 16,
  parameter int unsigned ANALOG_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_edge,
  input  logic              recenter,
  input  logic              plus,
  input  logic              minus,
  input  logic              analog_en,
  input  logic signed [7:0] analog,
  output logic [POS_W-1:0]  pos,
  output logic              moved
);

  localparam int unsigned SPD_W = $clog2(SPEED_MAX + 1);
  localparam int unsigned CNT_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [SPD_W-1:0] SPD_MIN = SPD_W'(SPEED_MIN);
  localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(SPEED_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(ACCEL_TICKS);

  axis_state_t       state, state_nxt;
  logic [SPD_W-1:0]  speed, speed_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              dir, dir_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;

  logic [8:0]              a_ext;
  logic [8:0]              a_mag;
  logic                    analog_act;
  logic signed [7:0]       a_vel;
  logic signed [NXT_W-1:0] delta;
  logic [SPD_W-1:0]        spd_use;
  logic [CNT_W-1:0]        cnt_use;
  logic [CNT_W-1:0]        cnt_inc;
  logic [SPD_W:0]          spd_sum;

  // Magnitude in 9 bits so that -128 maps to 128 instead of overflowing.
  always_comb begin
    a_ext      = {analog[7], analog};
    a_mag      = a_ext[8] ? (~a_ext + 9'd1) : a_ext;
    analog_act = analog_en && (a_mag > 9'(DEADZONE));
    a_vel      = analog >>> ANALOG_SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      speed <= SPD_MIN;
      cnt   <= '0;
      dir   <= 1'b0;
      acc   <= ACC_W'(ACC_CENTER);
    end else begin
      state <= state_nxt;
      speed <= speed_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
      acc   <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    speed_nxt = speed;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    acc_nxt   = acc;
    delta     = '0;
    moved     = 1'b0;
    spd_use   = speed;
    cnt_use   = cnt;
    cnt_inc   = '0;
    spd_sum   = '0;

    if (recenter) begin
      state_nxt = IDLE;
      speed_nxt = SPD_MIN;
      cnt_nxt   = '0;
      acc_nxt   = ACC_W'(ACC_CENTER);
    end else if (tick_edge) begin
      if (analog_act) begin
        state_nxt = IDLE;
        speed_nxt = SPD_MIN;
        cnt_nxt   = '0;
        delta     = {{(NXT_W-8){a_vel[7]}}, a_vel};
      end else if (plus ^ minus) begin
        // A fresh press and a reversal both count this tick as the first at SPEED_MIN.
        if (state == IDLE || dir != plus) begin
          spd_use = SPD_MIN;
          cnt_use = '0;
        end
        dir_nxt = plus;
        delta   = $signed({{(NXT_W-SPD_W){1'b0}}, spd_use});
        if (!plus) delta = -delta;
        if (state == CRUISE && dir == plus) begin
          state_nxt = CRUISE;
        end else begin
          state_nxt = RAMP;
          speed_nxt = spd_use;
          cnt_inc   = cnt_use + CNT_W'(1);
          cnt_nxt   = cnt_inc;
          if (cnt_inc == CNT_TOP) begin
            cnt_nxt   = '0;
            spd_sum   = {1'b0, spd_use} + {1'b0, SPD_MIN};
            speed_nxt = (spd_sum >= {1'b0, SPD_MAX}) ? SPD_MAX : spd_sum[SPD_W-1:0];
            if (speed_nxt == SPD_MAX) state_nxt = CRUISE;
          end
        end
      end else begin
        state_nxt = IDLE;
        speed_nxt = SPD_MIN;
        cnt_nxt   = '0;
      end
      moved   = (delta != '0);
      acc_nxt = sat_clamp($signed({2'b00, acc}) + delta);
    end
  end

  assign pos = acc[ACC_W-1:FRAC_W];

endmodule

// File: rtl/gun_position.sv
// Turkey Shoot gun crosshair feeder: 4 ms tick edge detect, axis mapping
// (X right+, Y down+) and the registered "moving" flag.
module gun_position
  import gun_position_pkg::*;
#(
  parameter int unsigned SPEED_MIN    = 4,
  parameter int unsigned SPEED_MAX    = 32,
  parameter int unsigned ACCEL_TICKS  = 8,
  parameter int unsigned DEADZONE     = 16,
  parameter int unsigned ANALOG_SHIFT = 2
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  gun_position_if.slave  bus
);

  logic tick_q;
  logic tick_edge;
  logic x_moved;
  logic y_moved;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) tick_q <= 1'b0;
    else          tick_q <= bus.tick_4ms;
  end

  assign tick_edge = bus.tick_4ms & ~tick_q;

  gun_axis #(
    .SPEED_MIN    (SPEED_MIN),
    .SPEED_MAX    (SPEED_MAX),
    .ACCEL_TICKS  (ACCEL_TICKS),
    .DEADZONE     (DEADZONE),
    .ANALOG_SHIFT (ANALOG_SHIFT)
  ) u_axis_x (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .tick_edge (tick_edge),
    .recenter  (bus.recenter),
    .plus      (bus.joy_right),
    .minus     (bus.joy_left),
    .analog_en (bus.analog_en),
    .analog    (bus.analog_x),
    .pos       (bus.gun_h),
    .moved     (x_moved)
  );

  gun_axis #(
    .SPEED_MIN    (SPEED_MIN),
    .SPEED_MAX    (SPEED_MAX),
    .ACCEL_TICKS  (ACCEL_TICKS),
    .DEADZONE     (DEADZONE),
    .ANALOG_SHIFT (ANALOG_SHIFT)
  ) u_axis_y (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .tick_edge (tick_edge),
    .recenter  (bus.recenter),
    .plus      (bus.joy_down),
    .minus     (bus.joy_up),
    .analog_en (bus.analog_en),
    .analog    (bus.analog_y),
    .pos       (bus.gun_v),
    .moved     (y_moved)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       bus.moving <= 1'b0;
    else if (bus.recenter) bus.moving <= 1'b0;
    else if (tick_edge) bus.moving <= x_moved | y_moved;
  end

endmodule

// File: tb/tb_gun_position.sv
// Self-checking bench for gun_position: directed scenarios plus random input runs
// against a held-duration reference model of the crosshair motion.
module tb_gun_position;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  gun_position_if bus();

  gun_position dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference state: fixed-point position, length of the current same-direction run, direction.
  int m_acc[2];
  int m_run[2];
  int m_dir[2];
  bit m_mov;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 32 * 16;
      m_run[i] = 0;
      m_dir[i] = 0;
    end
    m_mov = 1'b0;
  endtask

  // Speed depends only on how many consecutive ticks one direction has been held.
  task automatic model_axis(input int i, input bit p, input bit n, input bit en,
                            input int a, output bit mv);
    int d;
    int spd;
    int delta;
    delta = 0;
    if (en && (a > 16 || a < -16)) begin
      delta    = a >>> 2;
      m_run[i] = 0;
      m_dir[i] = 0;
    end else if (p != n) begin
      d        = p ? 1 : -1;
      m_run[i] = (d == m_dir[i]) ? m_run[i] + 1 : 1;
      m_dir[i] = d;
      spd      = 4 * (1 + (m_run[i] - 1) / 8);
      if (spd > 32) spd = 32;
      delta = d * spd;
    end else begin
      m_run[i] = 0;
      m_dir[i] = 0;
    end
    mv = (delta != 0);
    m_acc[i] += delta;
    if (m_acc[i] < 0)    m_acc[i] = 0;
    if (m_acc[i] > 1023) m_acc[i] = 1023;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "/gun_h"},  int'(bus.gun_h),  m_acc[0] >> 4);
    check_eq({tag, "/gun_v"},  int'(bus.gun_v),  m_acc[1] >> 4);
    check_eq({tag, "/moving"}, int'(bus.moving), int'(m_mov));
  endtask

  task automatic do_tick(input int hold, input bit rc, input string tag);
    bit mx;
    bit my;
    @(negedge clk_sys);
    bus.tick_4ms = 1'b1;
    bus.recenter = rc;
    if (rc) begin
      model_reset();
    end else begin
      model_axis(0, bus.joy_right, bus.joy_left, bus.analog_en, int'(bus.analog_x), mx);
      model_axis(1, bus.joy_down,  bus.joy_up,   bus.analog_en, int'(bus.analog_y), my);
      m_mov = mx | my;
    end
    @(negedge clk_sys);
    bus.recenter = 1'b0;
    check_outputs(tag);
    repeat (hold) @(negedge clk_sys);
    bus.tick_4ms = 1'b0;
  endtask

  function automatic logic signed [7:0] pick_analog();
    case ($urandom_range(0, 6))
      0:       return -8'sd128;
      1:       return 8'sd127;
      2:       return 8'sd16;
      3:       return -8'sd16;
      4:       return 8'sd17;
      5:       return -8'sd17;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic set_joy(input bit r, input bit l, input bit d, input bit u);
    bus.joy_right = r;
    bus.joy_left  = l;
    bus.joy_down  = d;
    bus.joy_up    = u;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.tick_4ms  = 1'b0;
    bus.recenter  = 1'b0;
    bus.analog_en = 1'b0;
    bus.analog_x  = '0;
    bus.analog_y  = '0;
    set_joy(0, 0, 0, 0);

    // Test 1: asynchronous reset, then idle ticks
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst/gun_h", int'(bus.gun_h), 32);
    check_eq("rst/gun_v", int'(bus.gun_v), 32);
    check_eq("rst/moving", int'(bus.moving), 0);
    model_reset();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    for (int t = 0; t < 20; t++) do_tick(1, 1'b0, "idle");
    check_eq("idle/gun_h", int'(bus.gun_h), 32);

    // Test 2: digital ramp to the right from centre
    set_joy(1, 0, 0, 0);
    for (int t = 1; t <= 16; t++) begin
      do_tick(1, 1'b0, "ramp");
      if (t == 8)  check_eq("ramp8/gun_h", int'(bus.gun_h), 34);
      if (t == 16) check_eq("ramp16/gun_h", int'(bus.gun_h), 38);
    end
    set_joy(0, 0, 0, 0);
    do_tick(1, 1'b0, "rel");

    // Test 3: clamp at both ends, cruise observed from the left edge
    set_joy(0, 1, 0, 0);
    for (int t = 0; t < 80; t++) do_tick(0, 1'b0, "left");
    check_eq("clamp0/gun_h", int'(bus.gun_h), 0);
    set_joy(0, 0, 0, 0);
    do_tick(1, 1'b0, "rel");
    set_joy(1, 0, 0, 0);
    do_tick(1, 1'b0, "nudge");
    check_eq("acc4/gun_h", int'(bus.gun_h), 0);
    set_joy(0, 0, 0, 0);
    do_tick(1, 1'b0, "rel");
    set_joy(1, 0, 0, 0);
    for (int t = 1; t <= 58; t++) begin
      do_tick(0, 1'b0, "cruise");
      if (t == 57) check_eq("cruise57/gun_h", int'(bus.gun_h), 58);
      if (t == 58) check_eq("cruise58/gun_h", int'(bus.gun_h), 60);
    end
    check_eq("cruise/gun_v", int'(bus.gun_v), 32);
    set_joy(0, 0, 1, 0);
    for (int t = 0; t < 100; t++) do_tick(0, 1'b0, "down");
    check_eq("clamp63/gun_v", int'(bus.gun_v), 63);
    set_joy(0, 0, 0, 0);
    do_tick(1, 1'b0, "rel");

    // Test 4: opposing pair, then reversal after a partial ramp
    do_tick(1, 1'b1, "rc");
    set_joy(1, 1, 0, 0);
    for (int t = 0; t < 10; t++) do_tick(0, 1'b0, "both");
    check_eq("both/gun_h", int'(bus.gun_h), 32);
    check_eq("both/moving", int'(bus.moving), 0);
    set_joy(1, 0, 0, 0);
    for (int t = 0; t < 20; t++) do_tick(0, 1'b0, "r20");
    check_eq("r20/gun_h", int'(bus.gun_h), 41);
    set_joy(0, 1, 0, 0);
    do_tick(1, 1'b0, "rev");
    check_eq("rev/gun_h", int'(bus.gun_h), 40);
    set_joy(0, 0, 0, 0);

    // Test 5: analog path, deadzone fallback, -128 extreme
    do_tick(1, 1'b1, "rc");
    bus.analog_en = 1'b1;
    bus.analog_x  = 8'sd64;
    for (int t = 0; t < 4; t++) do_tick(0, 1'b0, "an64");
    check_eq("an64/gun_h", int'(bus.gun_h), 36);
    bus.analog_x = 8'sd10;
    set_joy(1, 0, 0, 0);
    for (int t = 0; t < 4; t++) do_tick(0, 1'b0, "andz");
    check_eq("andz/gun_h", int'(bus.gun_h), 37);
    set_joy(0, 0, 0, 0);
    bus.analog_x = -8'sd128;
    for (int t = 0; t < 40; t++) do_tick(0, 1'b0, "an128");
    check_eq("an128/gun_h", int'(bus.gun_h), 0);

    // Test 6: long tick level gives one update; recenter beats a coincident tick
    do_tick(1, 1'b1, "rc");
    bus.analog_x = 8'sd64;
    do_tick(50, 1'b0, "long");
    check_eq("long/gun_h", int'(bus.gun_h), 33);
    check_eq("long/moving", int'(bus.moving), 1);
    do_tick(1, 1'b1, "rc_tick");
    check_eq("rc_tick/gun_h", int'(bus.gun_h), 32);
    check_eq("rc_tick/moving", int'(bus.moving), 0);
    bus.analog_en = 1'b0;
    bus.analog_x  = '0;

    // Reset asserted mid-ramp acts immediately
    set_joy(1, 0, 1, 0);
    for (int t = 0; t < 12; t++) do_tick(0, 1'b0, "preset");
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check_eq("midrst/gun_h", int'(bus.gun_h), 32);
    check_eq("midrst/gun_v", int'(bus.gun_v), 32);
    check_eq("midrst/moving", int'(bus.moving), 0);
    model_reset();
    @(negedge clk_sys);
    reset_n = 1'b1;
    do_tick(1, 1'b0, "postrst");

    // Random runs of held inputs
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        {bus.joy_right, bus.joy_left, bus.joy_down, bus.joy_up} = 4'($urandom);
        bus.analog_en = ($urandom_range(0, 2) == 0);
        bus.analog_x  = pick_analog();
        bus.analog_y  = pick_analog();
      end
      do_tick($urandom_range(0, 3), ($urandom_range(0, 59) == 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
